// File: rtl/ks_seq_pkg.sv
// Shared types and helpers for the limb-serial Kogge-Stone add/subtract sequencer.
package ks_seq_pkg;

    localparam int LIMB_W = 11;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Bit offset of limb idx inside a wide operand.
    function automatic int unsigned limbBase(input int unsigned idx);
        return idx * LIMB_W;
    endfunction

endpackage

// File: rtl/PPA_Kogge_Stone_11bit.sv
// 11-bit Kogge-Stone parallel-prefix adder with carry in and carry out.
module PPA_Kogge_Stone_11bit
    import ks_seq_pkg::*;
(
    input  logic [LIMB_W-1:0] i_a,
    input  logic [LIMB_W-1:0] i_b,
    input  logic              i_cin,
    output logic [LIMB_W-1:0] o_sum,
    output logic              o_cout
);

    localparam int LEVELS = $clog2(LIMB_W);

    logic [LIMB_W-1:0] w_x;
    logic [LIMB_W-1:0] w_g;
    logic [LIMB_W-1:0] w_p;

    // Prefix levels are updated in place; walking from the MSB down keeps the
    // lower bits at their previous-level values while they are still needed.
    always_comb begin
        w_x    = i_a ^ i_b;
        w_p    = w_x;
        w_g    = i_a & i_b;
        w_g[0] = (i_a[0] & i_b[0]) | (w_x[0] & i_cin);
        for (int lvl = 0; lvl < LEVELS; lvl++) begin
            for (int i = LIMB_W - 1; i >= (1 << lvl); i--) begin
                w_g[i] = w_g[i] | (w_p[i] & w_g[i - (1 << lvl)]);
                w_p[i] = w_p[i] & w_p[i - (1 << lvl)];
            end
        end
        o_sum  = w_x ^ {w_g[LIMB_W-2:0], i_cin};
        o_cout = w_g[LIMB_W-1];
    end

endmodule

// File: rtl/ks_multiword_addsub_seq.sv
// Multi-precision add/subtract: streams LIMBS limbs, LSB first, through one shared
// 11-bit Kogge-Stone adder, chaining the carry through a register.
module ks_multiword_addsub_seq #(
    parameter int LIMB_W = 11,
    parameter int LIMBS  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      op_sub,
    input  logic [LIMB_W*LIMBS-1:0]   a,
    input  logic [LIMB_W*LIMBS-1:0]   b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LIMB_W*LIMBS-1:0]   sum,
    output logic                      cout,
    output logic                      ovf,
    output logic                      busy
);

    import ks_seq_pkg::*;

    localparam int W    = LIMB_W * LIMBS;
    localparam int IDXW = $clog2(LIMBS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LIMBS - 1);

    state_t             r_state;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic               r_op;
    logic [IDXW-1:0]    r_idx;
    logic               r_carry;
    logic [W-LIMB_W-1:0] r_acc;
    logic [W-1:0]       r_sum;
    logic               r_cout;
    logic               r_ovf;

    logic [LIMB_W-1:0]  w_limbA;
    logic [LIMB_W-1:0]  w_limbB;
    logic [LIMB_W-1:0]  w_s;
    logic               w_cout;

    assign w_limbA = r_a[limbBase(32'(r_idx)) +: LIMB_W];
    assign w_limbB = r_b[limbBase(32'(r_idx)) +: LIMB_W] ^ {LIMB_W{r_op}};

    PPA_Kogge_Stone_11bit u_adder (
        .i_a    (w_limbA),
        .i_b    (w_limbB),
        .i_cin  (r_carry),
        .o_sum  (w_s),
        .o_cout (w_cout)
    );

    // Lower limbs collect in r_acc so the visible sum changes only on the final limb.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= 1'b0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_op    <= op_sub;
                        r_idx   <= '0;
                        r_carry <= op_sub;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_carry <= w_cout;
                    if (r_idx == LAST_IDX) begin
                        r_sum   <= {w_s, r_acc};
                        r_cout  <= w_cout;
                        r_ovf   <= (r_a[W-1] == w_limbB[LIMB_W-1]) &&
                                   (w_s[LIMB_W-1] != r_a[W-1]);
                        r_state <= DONE;
                    end else begin
                        r_acc[limbBase(32'(r_idx)) +: LIMB_W] <= w_s;
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_ks_multiword_addsub_seq.sv
// Directed-vector and random bench for the limb-serial add/subtract sequencer.
module tb_ks_multiword_addsub_seq;

    localparam int LIMB_W = 11;
    localparam int LIMBS  = 4;
    localparam int W      = LIMB_W * LIMBS;
    localparam int NVEC   = 10;
    localparam int NRAND  = 1000;

    typedef struct {
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] expSum;
        logic         expCout;
        logic         expOvf;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         op_sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_ready = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    int nChecks = 0;
    int nFails  = 0;

    vec_t vecs[NVEC];

    ks_multiword_addsub_seq #(.LIMB_W(LIMB_W), .LIMBS(LIMBS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Independent W-bit reference: {ovf, cout, sum}
    function automatic logic [W+1:0] model(input logic op, input logic [W-1:0] va, input logic [W-1:0] vb);
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic         v;
        bb   = op ? ~vb : vb;
        full = {1'b0, va} + {1'b0, bb} + {{W{1'b0}}, op};
        v    = (va[W-1] == bb[W-1]) && (full[W-1] != va[W-1]);
        return {v, full};
    endfunction

    task automatic applyStimulus(input logic op, input logic [W-1:0] va, input logic [W-1:0] vb);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkBit("in_ready before request", in_ready, 1'b1);
        op_sub   = op;
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic waitValid(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL out_valid timeout: got 0, expected 1 within 50 cycles");
        end
    endtask

    task automatic checkOutput(input string tag, input logic [W-1:0] es, input logic ec, input logic eo);
        checkVal({tag, " sum"}, sum, es);
        checkBit({tag, " cout"}, cout, ec);
        checkBit({tag, " ovf"}, ovf, eo);
        checkBit({tag, " in_ready in DONE"}, in_ready, 1'b0);
        checkBit({tag, " busy in DONE"}, busy, 1'b1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkBit({tag, " out_valid after handshake"}, out_valid, 1'b0);
        checkBit({tag, " in_ready after handshake"}, in_ready, 1'b1);
    endtask

    initial begin
        int           lat;
        int           nResults;
        int           sawValid;
        logic         rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W+1:0] exp;

        vecs[0] = '{1'b0, 44'hFFFFFFFFFFF, 44'h00000000001, 44'h00000000000, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 44'h00000000005, 44'h00000000007, 44'hFFFFFFFFFFE, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 44'h00000000007, 44'h00000000005, 44'h00000000002, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 44'h7FFFFFFFFFF, 44'h00000000001, 44'h80000000000, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 44'h80000000000, 44'h00000000001, 44'h7FFFFFFFFFF, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 44'h12345678901, 44'h00000000FFF, 44'h12345679900, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 44'h00000000000, 44'h00000000000, 44'h00000000000, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 44'h80000000000, 44'h80000000000, 44'h00000000000, 1'b1, 1'b1};
        vecs[8] = '{1'b0, 44'h00000000400, 44'h00000000400, 44'h00000000800, 1'b0, 1'b0};
        vecs[9] = '{1'b1, 44'h7FFFFFFFFFF, 44'h80000000000, 44'hFFFFFFFFFFF, 1'b0, 1'b1};

        #2 rst_n = 1'b0;
        #1;
        checkBit("reset in_ready", in_ready, 1'b1);
        checkBit("reset out_valid", out_valid, 1'b0);
        checkBit("reset busy", busy, 1'b0);
        checkVal("reset sum", sum, '0);
        checkBit("reset cout", cout, 1'b0);
        checkBit("reset ovf", ovf, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed vectors");
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
            checkBit($sformatf("v%0d busy in RUN", i), busy, 1'b1);
            waitValid(lat);
            checkInt($sformatf("v%0d latency", i), lat, LIMBS);
            checkOutput($sformatf("v%0d", i), vecs[i].expSum, vecs[i].expCout, vecs[i].expOvf);
        end

        $display("[TB] backpressure");
        applyStimulus(1'b0, 44'h00000000123, 44'h00000000456);
        waitValid(lat);
        for (int k = 0; k < 5; k++) begin
            out_ready = 1'b0;
            in_valid  = k[0];
            op_sub    = 1'b1;
            a         = W'({$urandom, $urandom});
            b         = W'({$urandom, $urandom});
            @(negedge clk);
            checkVal($sformatf("stall%0d sum", k), sum, 44'h00000000579);
            checkBit($sformatf("stall%0d cout", k), cout, 1'b0);
            checkBit($sformatf("stall%0d ovf", k), ovf, 1'b0);
            checkBit($sformatf("stall%0d in_ready", k), in_ready, 1'b0);
            checkBit($sformatf("stall%0d out_valid", k), out_valid, 1'b1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkBit("release out_valid", out_valid, 1'b0);
        checkBit("release in_ready", in_ready, 1'b1);
        @(negedge clk);
        checkBit("release no second result", out_valid, 1'b0);
        checkBit("release stays idle", busy, 1'b0);

        $display("[TB] reset mid-run");
        applyStimulus(1'b0, 44'h11111111111, 44'h22222222222);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkBit("midrst out_valid", out_valid, 1'b0);
        checkBit("midrst busy", busy, 1'b0);
        checkBit("midrst in_ready", in_ready, 1'b1);
        checkVal("midrst sum", sum, '0);
        checkBit("midrst cout", cout, 1'b0);
        checkBit("midrst ovf", ovf, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        sawValid = 0;
        for (int k = 0; k < LIMBS + 2; k++) begin
            @(negedge clk);
            if (out_valid) sawValid++;
        end
        checkInt("midrst discarded result", sawValid, 0);
        checkBit("midrst in_ready after release", in_ready, 1'b1);
        applyStimulus(1'b0, 44'h12345678901, 44'h00000000FFF);
        waitValid(lat);
        checkOutput("post-reset add", 44'h12345679900, 1'b0, 1'b0);

        $display("[TB] random transactions");
        nResults = 0;
        for (int t = 0; t < NRAND; t++) begin
            rop = 1'($urandom);
            ra  = W'({$urandom, $urandom});
            rb  = W'({$urandom, $urandom});
            if (t % 50 == 0) ra = {1'b0, {(W-1){1'b1}}};
            if (t % 70 == 0) rb = {1'b1, {(W-1){1'b0}}};
            exp = model(rop, ra, rb);
            applyStimulus(rop, ra, rb);
            lat = 0;
            while (!out_valid && lat < 50) begin
                out_ready = 1'($urandom);
                @(negedge clk);
                lat++;
            end
            out_ready = 1'b0;
            if (out_valid) begin
                nResults++;
                repeat ($urandom_range(0, 3)) @(negedge clk);
                checkOutput($sformatf("rnd%0d", t), exp[W-1:0], exp[W], exp[W+1]);
            end else begin
                checkBit($sformatf("rnd%0d out_valid", t), out_valid, 1'b1);
            end
        end
        checkInt("random result count", nResults, NRAND);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
